// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
// The CHK state is present only when PROG_LOADER_CHECKSUM_EN is defined.
package prog_loader_pkg;

  localparam int unsigned DEFAULT_DEPTH = 256;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA_LO,
    DATA_HI,
`ifdef PROG_LOADER_CHECKSUM_EN
    CHK,
`endif
    RUN,
    ERROR
  } state_t;

endpackage

// File: rtl/prog_mem.sv
// Instruction store: DEPTH x 16, synchronous write, combinational read.
// Contents are deliberately not reset.
module prog_mem #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: length-prefixed 16-bit words into prog_mem, then RUN.
// Optional trailing XOR checksum byte when PROG_LOADER_CHECKSUM_EN is defined.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        rx_ready,
  input  logic [15:0] instrAddr,
  output logic [15:0] instr,
  output logic        cpu_reset,
  output logic        load_done,
  output logic        load_err
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t LOAD_END = CHK;
`else
  localparam state_t LOAD_END = RUN;
`endif

  state_t      state, next_state;
  logic [7:0]  low;
  logic [15:0] n;
  logic [16:0] wptr;
  logic        xfer;
  logic        mem_we;
  logic [15:0] rd_data;
  logic [15:0] len_word;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign xfer     = rx_valid & rx_ready;
  assign len_word = {rx_byte, low};

  always_comb begin
    next_state = state;
    mem_we     = 1'b0;
    case (state)
      LEN_LO:  if (xfer) next_state = LEN_HI;
      LEN_HI: begin
        if (xfer) begin
          if (len_word == 16'd0)                 next_state = LOAD_END;
          else if ({1'b0, len_word} > DEPTH_W)   next_state = ERROR;
          else                                   next_state = DATA_LO;
        end
      end
      DATA_LO: if (xfer) next_state = DATA_HI;
      DATA_HI: begin
        if (xfer) begin
          mem_we = 1'b1;
          if ((wptr + 17'd1) < {1'b0, n}) next_state = DATA_LO;
          else                            next_state = LOAD_END;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CHK: begin
        if (xfer) next_state = (rx_byte == csum) ? RUN : ERROR;
      end
`endif
      RUN:     next_state = RUN;
      ERROR:   next_state = ERROR;
      default: next_state = LEN_LO;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= LEN_LO;
      low       <= '0;
      n         <= '0;
      wptr      <= '0;
      cpu_reset <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      state     <= next_state;
      // Registered from next_state so the CPU is released on the final-byte edge.
      cpu_reset <= (next_state != RUN);
      if (xfer && (state == LEN_LO || state == DATA_LO)) low <= rx_byte;
      if (xfer && state == LEN_HI) n <= len_word;
      if (mem_we) wptr <= wptr + 17'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
      if (xfer && (state == DATA_LO || state == DATA_HI)) csum <= csum ^ rx_byte;
`endif
    end
  end

  assign rx_ready  = (state != RUN) && (state != ERROR);
  assign load_done = (state == RUN);
  assign load_err  = (state == ERROR);
  assign instr     = (state == RUN && instrAddr < n) ? rd_data : '0;

  prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wptr[AW-1:0]),
    .wdata ({rx_byte, low}),
    .raddr (instrAddr[AW-1:0]),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (DEPTH=256); honours PROG_LOADER_CHECKSUM_EN.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_ready;
  logic [15:0] instrAddr;
  logic [15:0] instr;
  logic        cpu_reset;
  logic        load_done;
  logic        load_err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] exp;
  } rd_vec_t;

  rd_vec_t rv[5];

  always #5 clk = ~clk;

  prog_loader #(.DEPTH(256)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .rx_ready  (rx_ready),
    .instrAddr (instrAddr),
    .instr     (instr),
    .cpu_reset (cpu_reset),
    .load_done (load_done),
    .load_err  (load_err)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    if (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_byte  = 8'hA5;
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_rx_ready",  {15'd0, rx_ready},  16'd1);
    chk("rst_cpu_reset", {15'd0, cpu_reset}, 16'd1);
    chk("rst_load_done", {15'd0, load_done}, 16'd0);
    chk("rst_load_err",  {15'd0, load_err},  16'd0);
    chk("rst_instr",     instr,              16'h0000);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Loads 02 00 34 12 78 56 (+08) and checks release timing and readback table.
  task automatic load_std(input bit gap);
    logic [7:0] q[$];
    q = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
`ifdef PROG_LOADER_CHECKSUM_EN
    q.push_back(8'h08);
`endif
    for (int i = 0; i < q.size(); i++) begin
      if (i == 4) begin
        instrAddr = 16'h0000;
        #1;
        chk("instr_mid_load", instr, 16'h0000);
      end
      if (i == q.size() - 1) begin
        chk("cpu_reset_before_last", {15'd0, cpu_reset}, 16'd1);
        chk("rx_ready_before_last",  {15'd0, rx_ready},  16'd1);
      end
      send(q[i], gap);
    end
    chk("cpu_reset_after_last", {15'd0, cpu_reset}, 16'd0);
    chk("load_done_run",        {15'd0, load_done}, 16'd1);
    chk("rx_ready_run",         {15'd0, rx_ready},  16'd0);
    chk("load_err_run",         {15'd0, load_err},  16'd0);
    for (int i = 0; i < 5; i++) begin
      instrAddr = rv[i].addr;
      #1;
      chk($sformatf("instr@%h", rv[i].addr), instr, rv[i].exp);
    end
  endtask

  initial begin
    rv[0] = '{16'h0000, 16'h1234};
    rv[1] = '{16'h0001, 16'h5678};
    rv[2] = '{16'h0002, 16'h0000};
    rv[3] = '{16'h00FF, 16'h0000};
    rv[4] = '{16'hFFFF, 16'h0000};

    reset     = 1'b1;
    rx_valid  = 1'b0;
    rx_byte   = 8'h00;
    instrAddr = 16'h0000;
    do_reset();

    // Basic two-word program.
    load_std(1'b0);

    // Empty program: stale memory must stay hidden.
    do_reset();
    send(8'h00, 1'b0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(8'h00, 1'b0);
`endif
    chk("n0_cpu_reset_pre", {15'd0, cpu_reset}, 16'd1);
    send(8'h00, 1'b0);
    chk("n0_load_done", {15'd0, load_done}, 16'd1);
    chk("n0_cpu_reset", {15'd0, cpu_reset}, 16'd0);
    for (int a = 0; a < 2; a++) begin
      instrAddr = 16'(a);
      #1;
      chk("n0_instr", instr, 16'h0000);
    end

    // N=257 exceeds DEPTH.
    do_reset();
    send(8'h01, 1'b0);
    send(8'h01, 1'b0);
    send(8'h00, 1'b0);
    chk("big_load_err",  {15'd0, load_err},  16'd1);
    chk("big_rx_ready",  {15'd0, rx_ready},  16'd0);
    chk("big_cpu_reset", {15'd0, cpu_reset}, 16'd1);
    chk("big_load_done", {15'd0, load_done}, 16'd0);
    instrAddr = 16'h0000;
    #1;
    chk("big_instr", instr, 16'h0000);

    // N=256 is exactly DEPTH and must be accepted.
    do_reset();
    send(8'h00, 1'b0);
    send(8'h01, 1'b0);
    chk("n256_load_err", {15'd0, load_err}, 16'd0);
    chk("n256_rx_ready", {15'd0, rx_ready}, 16'd1);

    // Stalled stream with rx_valid toggling.
    do_reset();
    load_std(1'b1);

    // Reset mid-load, then full stream.
    do_reset();
    send(8'h02, 1'b0);
    send(8'h00, 1'b0);
    send(8'h34, 1'b0);
    do_reset();
    load_std(1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Bad checksum.
    do_reset();
    send(8'h02, 1'b0);
    send(8'h00, 1'b0);
    send(8'h34, 1'b0);
    send(8'h12, 1'b0);
    send(8'h78, 1'b0);
    send(8'h56, 1'b0);
    send(8'h09, 1'b0);
    chk("badck_load_err",  {15'd0, load_err},  16'd1);
    chk("badck_load_done", {15'd0, load_done}, 16'd0);
    chk("badck_cpu_reset", {15'd0, cpu_reset}, 16'd1);
    instrAddr = 16'h0000;
    #1;
    chk("badck_instr", instr, 16'h0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
